// File: rtl/pipelined_datapath_if.sv
// ============================================================================
//  Module      : pipelined_datapath_if
//  Description : Issue and result handshake bundle for pipelined_datapath.
//                master  - fetch/control side plus result consumer
//                          (drives instr_valid, instr, data_in, out_ready)
//                slave   - the datapath
//                          (drives instr_ready, out_valid, out_result,
//                           out_rd, out_we [, out_flags])
//                out_flags exists only when DATAPATH_FLAGS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipelined_datapath_if #(
  parameter int WIDTH = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_rd;
  logic             out_we;
`ifdef DATAPATH_FLAGS_EN
  logic [3:0]       out_flags;

  modport master (
    output instr_valid, instr, data_in, out_ready,
    input  instr_ready, out_valid, out_result, out_rd, out_we, out_flags
  );
  modport slave (
    input  instr_valid, instr, data_in, out_ready,
    output instr_ready, out_valid, out_result, out_rd, out_we, out_flags
  );
`else
  modport master (
    output instr_valid, instr, data_in, out_ready,
    input  instr_ready, out_valid, out_result, out_rd, out_we
  );
  modport slave (
    input  instr_valid, instr, data_in, out_ready,
    output instr_ready, out_valid, out_result, out_rd, out_we
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pipelined_datapath.sv
// ============================================================================
//  Module      : pipelined_datapath
//  Description : Three-stage pipelined datapath: instruction latch (S1),
//                operand read + ALU (combinational from S1), writeback
//                register (S2 = output port). Retiring S2 writes the register
//                file and is forwarded to the S1 operand read, so dependent
//                instructions issue back to back with no bubbles.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous, active-high
//                bus (slave)  - issue handshake (instr_valid/instr_ready,
//                               instr, data_in) and result handshake
//                               (out_valid/out_ready, out_result, out_rd,
//                               out_we, out_flags)
//  Options     : DATAPATH_FLAGS_EN - adds registered {N,Z,C,V} on out_flags
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipelined_datapath_if.slave   bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  // S1 instruction latch
  logic             s1_valid;
  logic             s1_wb_sel;
  logic             s1_we;
  logic [3:0]       s1_op;
  logic [IDX_W-1:0] s1_rs;
  logic [IDX_W-1:0] s1_rt;
  logic [4:0]       s1_rd;
  logic [WIDTH-1:0] s1_data;

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             advance;
  logic [IDX_W-1:0] wb_idx;
  logic             wb_hit;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result;
  logic             unused_instr;

  // Only the low IDX_W bits of rs/rt and none of instr[10:0] are architectural.
  assign unused_instr = ^{bus.instr[25:16], bus.instr[10:0]};

  // The whole pipe moves as one: S2 can be overwritten only once it has
  // been consumed or is empty.
  assign advance         = !bus.out_valid | bus.out_ready;
  assign bus.instr_ready = advance;

  assign wb_idx = bus.out_rd[IDX_W-1:0];
  assign wb_hit = bus.out_valid & bus.out_we & (wb_idx != '0);

  // Operand read. The retiring instruction in S2 has not reached the register
  // file yet, so it is forwarded; anything older is already in regs.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (s1_rs != '0) begin
      op_a = (wb_hit && (wb_idx == s1_rs)) ? bus.out_result : regs[s1_rs];
    end
    if (s1_rt != '0) begin
      op_b = (wb_hit && (wb_idx == s1_rt)) ? bus.out_result : regs[s1_rt];
    end
  end

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_res = op_a;
    case (s1_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_res = op_a;
    endcase
  end

  assign result = s1_wb_sel ? s1_data : alu_res;

`ifdef DATAPATH_FLAGS_EN
  logic [3:0] flags_next;

  // Carry out of an add shows up as a wrapped sum smaller than an addend;
  // for subtract C is "no borrow", i.e. A >= B unsigned.
  always_comb begin
    flags_next = {result[MSB], (result == '0), 2'b00};
    if (!s1_wb_sel) begin
      if (s1_op == OP_ADD) begin
        flags_next[1] = (alu_res < op_a);
        flags_next[0] = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end else if (s1_op == OP_SUB) begin
        flags_next[1] = (op_a >= op_b);
        flags_next[0] = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
    end
  end
`endif

  // S1 latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_wb_sel <= 1'b0;
      s1_we     <= 1'b0;
      s1_op     <= '0;
      s1_rs     <= '0;
      s1_rt     <= '0;
      s1_rd     <= '0;
      s1_data   <= '0;
    end else if (advance) begin
      s1_valid  <= bus.instr_valid;
      s1_wb_sel <= bus.instr[31];
      s1_we     <= bus.instr[30];
      s1_op     <= bus.instr[29:26];
      s1_rs     <= bus.instr[21+IDX_W-1:21];
      s1_rt     <= bus.instr[16+IDX_W-1:16];
      s1_rd     <= bus.instr[15:11];
      s1_data   <= bus.instr_valid ? bus.data_in : s1_data;
    end
  end

  // S2 / output registers. Payload only changes when a real instruction
  // arrives so the port holds its last value across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_rd     <= '0;
      bus.out_we     <= 1'b0;
`ifdef DATAPATH_FLAGS_EN
      bus.out_flags  <= '0;
`endif
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_result <= result;
        bus.out_rd     <= s1_rd;
        bus.out_we     <= s1_we;
`ifdef DATAPATH_FLAGS_EN
        bus.out_flags  <= flags_next;
`endif
      end
    end
  end

  // Register file: written by the instruction leaving S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (advance && wb_hit) begin
      regs[wb_idx] <= bus.out_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
// ============================================================================
//  Module      : tb_pipelined_datapath
//  Description : Scoreboard bench for pipelined_datapath. Issued instructions
//                are executed in program order by an architectural model and
//                the expected retirement is queued; a monitor pops and
//                compares whenever the DUT retires a result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_datapath;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [4:0]       rd;
    logic             we;
    logic [3:0]       flags;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipelined_datapath_if #(.WIDTH(WIDTH)) bus ();

  pipelined_datapath #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t             sb [$];
  logic [WIDTH-1:0] model_regs [NUM_REGS];
  int               n_checks   = 0;
  int               n_pass     = 0;
  bit               mon_en     = 1'b0;
  int               ready_mode = 0;   // 0: always ready, 1: random, 2: never

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] enc(input bit wb, input bit we, input logic [3:0] op,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    return {wb, we, op, rs, rt, rd, 11'd0};
  endfunction

  // Architectural (sequential) execution of one instruction.
  function automatic exp_t model_exec(input logic [31:0] ins, input logic [WIDTH-1:0] d);
    exp_t             e;
    logic [WIDTH-1:0] a, b;
    longint           sa, sbv, sres;
    longint unsigned  ua, ub;
    longint           tmp;
    int               sh, rdi;
    longint           smax, smin;
    smax = (longint'(1) << (WIDTH-1)) - 1;
    smin = -(longint'(1) << (WIDTH-1));
    a   = model_regs[int'(ins[25:21]) % NUM_REGS];
    b   = model_regs[int'(ins[20:16]) % NUM_REGS];
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    sh  = int'(b % WIDTH);
    e.rd    = ins[15:11];
    e.we    = ins[30];
    e.flags = '0;
    e.res   = a;
    case (ins[29:26])
      4'd0: begin
        e.res = a + b;
        e.flags[1] = ((ua + ub) >> WIDTH) != 0;
        sres = sa + sbv;
        e.flags[0] = (sres > smax) || (sres < smin);
      end
      4'd1: begin
        e.res = a - b;
        e.flags[1] = (ua >= ub);
        sres = sa - sbv;
        e.flags[0] = (sres > smax) || (sres < smin);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << sh;
      4'd6: e.res = a >> sh;
      4'd7: begin tmp = sa >>> sh; e.res = tmp[WIDTH-1:0]; end
      4'd8: begin e.res = '0; e.res[0] = (sa < sbv); end
      4'd9: begin e.res = '0; e.res[0] = (ua < ub); end
      default: e.res = a;
    endcase
    if (ins[31]) begin
      e.res   = d;
      e.flags = '0;
    end
    e.flags[3] = e.res[WIDTH-1];
    e.flags[2] = (e.res == '0);
    rdi = int'(ins[15:11]) % NUM_REGS;
    if (e.we && rdi != 0) model_regs[rdi] = e.res;
    return e;
  endfunction

  function automatic logic pick_ready();
    case (ready_mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [WIDTH-1:0] d);
    int waited = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.data_in     = d;
    bus.out_ready   = pick_ready();
    #1;
    while (!bus.instr_ready) begin
      waited++;
      if (waited > 100) begin
        chk("issue_timeout", 0, 1);
        bus.instr_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.out_ready = pick_ready();
      #1;
    end
    sb.push_back(model_exec(ins, d));
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.out_ready = pick_ready();
    end
  endtask

  task automatic drain();
    int guard = 0;
    ready_mode = 0;
    while (sb.size() != 0 && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compares each retirement against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.out_result, e.res);
          chk("rd", bus.out_rd, e.rd);
          chk("we", bus.out_we, e.we);
`ifdef DATAPATH_FLAGS_EN
          chk("flags", bus.out_flags, e.flags);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.data_in     = '0;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_we", bus.out_we, 0);
    chk("rst_instr_ready", bus.instr_ready, 1);
`ifdef DATAPATH_FLAGS_EN
    chk("rst_out_flags", bus.out_flags, 0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;

    // Loads then ADD r3 = r1 + r2; result appears one edge after capture
    ready_mode = 0;
    issue(enc(1, 1, 4'd0, 0, 0, 1), 32'd5);
    chk("lat_before", bus.out_valid, 0);
    issue(enc(1, 1, 4'd0, 0, 0, 2), 32'd7);
    chk("lat_after", bus.out_valid, 1);
    issue(enc(0, 1, 4'd0, 1, 2, 3), 32'd0);
    drain();

    // Back-to-back dependent instruction, no bubble
    issue(enc(1, 1, 4'd0, 0, 0, 1), 32'd3);
    issue(enc(0, 1, 4'd0, 1, 1, 4), 32'd0);
    chk("b2b_first_rd", bus.out_rd, 1);
    @(posedge clk);
    #1;
    chk("b2b_second_valid", bus.out_valid, 1);
    chk("b2b_second_rd", bus.out_rd, 4);
    drain();

    // Back-pressure with two valid instructions in the pipe
    ready_mode = 2;
    issue(enc(1, 1, 4'd0, 0, 0, 6), 32'h1234);
    issue(enc(0, 1, 4'd0, 6, 6, 7), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      chk("stall_instr_ready", bus.instr_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_result", bus.out_result, 32'h1234);
      chk("stall_out_rd", bus.out_rd, 6);
    end
    drain();
    issue(enc(0, 0, 4'd3, 6, 0, 8), 32'd0);
    issue(enc(0, 0, 4'd3, 7, 0, 9), 32'd0);
    drain();

    // r0 writes are ignored but out_we still reports the request
    issue(enc(1, 1, 4'd0, 0, 0, 0), 32'hFFFF);
    issue(enc(0, 1, 4'd3, 0, 0, 5), 32'd0);
    drain();

    // Arithmetic boundaries
    issue(enc(1, 1, 4'd0, 0, 0, 1), 32'd0);
    issue(enc(1, 1, 4'd0, 0, 0, 2), 32'd1);
    issue(enc(0, 1, 4'd1, 1, 2, 3), 32'd0);           // 0 - 1
    issue(enc(1, 1, 4'd0, 0, 0, 4), 32'h8000_0000);
    issue(enc(1, 1, 4'd0, 0, 0, 5), 32'd4);
    issue(enc(0, 1, 4'd7, 4, 5, 6), 32'd0);           // SRA
    issue(enc(1, 1, 4'd0, 0, 0, 7), 32'hFFFF_FFFF);
    issue(enc(0, 1, 4'd8, 7, 2, 8), 32'd0);           // SLT  -1 < 1
    issue(enc(0, 1, 4'd9, 7, 2, 9), 32'd0);           // SLTU -1 < 1
    issue(enc(1, 1, 4'd0, 0, 0, 10), 32'h7FFF_FFFF);
    issue(enc(0, 1, 4'd0, 10, 2, 11), 32'd0);         // overflowing ADD
    issue(enc(0, 1, 4'd1, 7, 7, 12), 32'd0);          // SUB equal, no borrow
    drain();

    // Randomised traffic with bubbles and random back-pressure
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31]    = ($urandom_range(0, 3) == 0);
      ins[30]    = ($urandom_range(0, 4) != 0);
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      issue(ins, $urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    drain();

    // Reset with two instructions in flight
    issue(enc(1, 1, 4'd0, 0, 0, 1), 32'hAA);
    issue(enc(1, 1, 4'd0, 0, 0, 2), 32'hBB);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    sb.delete();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", bus.out_valid, 0);
    for (int r = 1; r < 16; r++) begin
      issue(enc(0, 0, 4'd3, 5'(r), 5'(r), 0), 32'd0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
